// File: rtl/mod_uart.sv
// Memory-mapped 8N1 UART: command/status/rx/tx registers on daddr[3:2],
// independent TX and RX state machines timed by CLKS_PER_BIT baud counters.
module mod_uart #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic        drw,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        txd,
    input  logic        rxd
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  tx_buf_q, tx_buf_d;

    logic [1:0]  rx_sync_q;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_buf_q, rx_buf_d;
    logic        rx_ready_q, rx_ready_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;

    logic        wr_en, rd_en, cmd_wr, start_cmd, clr_cmd, txbuf_wr;
    logic        tx_ready, rx_line, stop_ok, stop_bad;
    logic [1:0]  sel;
    logic        unused_bits;

    assign sel       = daddr[3:2];
    assign wr_en     = de & drw;
    assign rd_en     = de & ~drw;
    assign cmd_wr    = wr_en && (sel == 2'd0);
    assign start_cmd = cmd_wr && din[0];
    assign clr_cmd   = cmd_wr && din[1];
    assign txbuf_wr  = wr_en && (sel == 2'd3);
    assign tx_ready  = (tx_state_q == ST_IDLE);
    assign rx_line   = rx_sync_q[1];
    assign unused_bits = ^{daddr[31:4], daddr[1:0], din[31:8]};

    // Transmitter: the in-flight byte lives in tx_shift_q, so tx_buf_q may be rewritten mid-frame.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = txbuf_wr ? din[7:0] : tx_buf_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    tx_state_d = ST_START;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_shift_d = tx_buf_q;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
        endcase
    end

    always_comb begin
        case (tx_state_q)
            ST_START: txd = 1'b0;
            ST_DATA:  txd = tx_shift_q[0];
            default:  txd = 1'b1;
        endcase
    end

    // Receiver: start bit is re-checked at mid-bit, then every sample lands mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_line) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = '0;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    if (!rx_line) begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                    end else begin
                        rx_state_d = ST_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_line, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = ST_IDLE;
                    stop_ok    = rx_line;
                    stop_bad   = ~rx_line;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
        endcase
    end

    // Flag sets are applied after the clear so a coincident set wins.
    always_comb begin
        rx_buf_d    = rx_buf_q;
        rx_ready_d  = rx_ready_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (clr_cmd) begin
            rx_ready_d  = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (stop_ok) begin
            rx_buf_d   = rx_shift_q;
            rx_ready_d = 1'b1;
            if (rx_ready_q) begin
                overrun_d = 1'b1;
            end
        end
        if (stop_bad) begin
            frame_err_d = 1'b1;
        end
    end

    always_comb begin
        dout = '0;
        if (rd_en) begin
            case (sel)
                2'd1:    dout = {28'd0, frame_err_q, overrun_q, rx_ready_q, tx_ready};
                2'd2:    dout = {24'd0, rx_buf_q};
                2'd3:    dout = {24'd0, tx_buf_q};
                default: dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state_q  <= ST_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            rx_sync_q   <= 2'b11;
            rx_state_q  <= ST_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_buf_q    <= '0;
            rx_ready_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            rx_sync_q   <= {rx_sync_q[0], rxd};
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_buf_q    <= rx_buf_d;
            rx_ready_q  <= rx_ready_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_mod_uart.sv
// Self-checking bench for mod_uart at CLKS_PER_BIT=4: a frame-level model of the
// registers and serial lines, checked every cycle, plus hand-computed literal checks.
module tb_mod_uart;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic        drw;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        txd;
    logic        rxd;

    always #5 clk = ~clk;

    mod_uart #(.CLKS_PER_BIT(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .de    (de),
        .drw   (drw),
        .daddr (daddr),
        .din   (din),
        .dout  (dout),
        .txd   (txd),
        .rxd   (rxd)
    );

    // Model state: tx is "cycles left in the current frame", rx flags change at scheduled stop samples.
    int         cyc = 0;
    int         tx_rem = 0;
    logic [9:0] m_frame = '1;
    logic [7:0] m_txbuf = '0;
    logic [7:0] m_rxbuf = '0;
    logic       m_rdy = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       exp_txd = 1'b1;
    logic       m_busy;
    logic       m_old_rdy;

    int         rx_ev_cycle = -1;
    logic [7:0] rx_ev_byte = '0;
    logic       rx_ev_ok = 1'b1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            tx_rem  = 0;
            m_txbuf = '0;
            m_rxbuf = '0;
            m_rdy   = 1'b0;
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
        end else begin
            m_busy    = (tx_rem != 0);
            m_old_rdy = m_rdy;
            if (tx_rem != 0) tx_rem = tx_rem - 1;
            if (de && drw) begin
                case (daddr[3:2])
                    2'd0: begin
                        if (din[0] && !m_busy) begin
                            tx_rem  = 10 * N;
                            m_frame = {1'b1, m_txbuf, 1'b0};
                        end
                        if (din[1]) begin
                            m_rdy  = 1'b0;
                            m_ovr  = 1'b0;
                            m_ferr = 1'b0;
                        end
                    end
                    2'd3: m_txbuf = din[7:0];
                    default: ;
                endcase
            end
            if (cyc == rx_ev_cycle) begin
                if (rx_ev_ok) begin
                    m_rxbuf = rx_ev_byte;
                    m_rdy   = 1'b1;
                    if (m_old_rdy) m_ovr = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
            end
        end
        exp_txd = (tx_rem == 0) ? 1'b1 : m_frame[(10 * N - tx_rem) / N];
    end

    int checks = 0;
    int failures = 0;
    int low_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic cmp_cycle();
        logic [31:0] e;
        e = '0;
        if (de && !drw) begin
            case (daddr[3:2])
                2'd1:    e = {28'd0, m_ferr, m_ovr, m_rdy, (tx_rem == 0)};
                2'd2:    e = {24'd0, m_rxbuf};
                2'd3:    e = {24'd0, m_txbuf};
                default: e = '0;
            endcase
        end
        check("model_txd", {31'd0, txd}, {31'd0, exp_txd});
        check("model_dout", dout, e);
        if (txd == 1'b0) low_cnt++;
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        de = 1'b1; drw = 1'b1; daddr = {28'd0, a, 2'b00}; din = d;
        tick();
        de = 1'b0; drw = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] mask,
                      input string name);
        de = 1'b1; drw = 1'b0; daddr = {28'd0, a, 2'b00};
        @(negedge clk);
        cmp_cycle();
        check(name, dout & mask, exp);
        @(posedge clk);
        #1;
        de = 1'b0;
    endtask

    // Stop sample lands 2 sync cycles + half a bit + 9 bits after the first edge seeing the start bit.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        rx_ev_byte  = b;
        rx_ev_ok    = stop;
        rx_ev_cycle = cyc + 1 + 2 + N / 2 + 9 * N;
        rxd = 1'b0;
        step(N);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            step(N);
        end
        rxd = stop;
        step(N);
        rxd = 1'b1;
        step(4);
    endtask

    logic [0:9] txb_a5 = 10'b0101001011;
    int         low0;

    initial begin
        rst = 1'b0; de = 1'b0; drw = 1'b0; daddr = '0; din = '0; rxd = 1'b1;
        @(posedge clk);
        #1;
        step(2);
        rst = 1'b1;
        step(1);

        rd(2'd1, 32'h1, 32'hFFFF_FFFF, "reset_status");
        rd(2'd0, 32'h0, 32'hFFFF_FFFF, "cmd_reads_zero");
        rd(2'd2, 32'h0, 32'hFFFF_FFFF, "reset_rxbuf");
        rd(2'd3, 32'h0, 32'hFFFF_FFFF, "reset_txbuf");
        check("reset_txd", {31'd0, txd}, 32'd1);

        // Transmit 0xA5 and pin the serial waveform bit by bit.
        wr(2'd3, 32'hFFFF_FFA5);
        rd(2'd3, 32'hA5, 32'hFFFF_FFFF, "txbuf_readback");
        wr(2'd0, 32'h1);
        for (int k = 0; k < 10 * N; k++) begin
            if (k == 20) begin
                de = 1'b1; drw = 1'b0; daddr = 32'h4;
            end
            @(negedge clk);
            cmp_cycle();
            check("tx_a5_bit", {31'd0, txd}, {31'd0, txb_a5[k / N]});
            if (k == 20) check("tx_busy_status", dout, 32'h0);
            @(posedge clk);
            #1;
            de = 1'b0;
        end
        rd(2'd1, 32'h1, 32'hFFFF_FFFF, "tx_done_status");

        // Receive 0x3C; flags checked on bits [3:1], tx_ready is covered by the model.
        rx_frame(8'h3C, 1'b1);
        rd(2'd1, 32'h2, 32'hE, "rx_status");
        rd(2'd2, 32'h3C, 32'hFFFF_FFFF, "rx_buf");
        rd(2'd1, 32'h2, 32'hE, "rx_ready_kept");
        wr(2'd0, 32'h2);
        rd(2'd1, 32'h0, 32'hE, "rx_cleared");

        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        rd(2'd1, 32'h6, 32'hE, "overrun_status");
        rd(2'd2, 32'h22, 32'hFFFF_FFFF, "overrun_buf");
        wr(2'd0, 32'h2);

        rx_frame(8'h55, 1'b0);
        rd(2'd1, 32'h8, 32'hE, "frame_err_status");
        rd(2'd2, 32'h22, 32'hFFFF_FFFF, "frame_err_buf");
        wr(2'd0, 32'h2);
        rd(2'd1, 32'h0, 32'hE, "frame_err_cleared");

        rxd = 1'b0;
        step(1);
        rxd = 1'b1;
        step(12);
        rd(2'd1, 32'h0, 32'hE, "glitch_status");
        rd(2'd2, 32'h22, 32'hFFFF_FFFF, "glitch_buf");

        // Second start mid-frame is ignored; one 0x5A frame holds txd low for 20 cycles.
        low0 = low_cnt;
        wr(2'd3, 32'h5A);
        wr(2'd0, 32'h1);
        step(14);
        wr(2'd0, 32'h1);
        wr(2'd3, 32'hC3);
        step(60);
        check("busy_low_cycles", low_cnt - low0, 32'd20);
        rd(2'd3, 32'hC3, 32'hFFFF_FFFF, "busy_txbuf");
        rd(2'd1, 32'h1, 32'hFFFF_FFFF, "busy_done_status");

        // Reset at cycle 15 of a frame.
        wr(2'd3, 32'h0F);
        wr(2'd0, 32'h1);
        step(15);
        rst = 1'b0;
        tick();
        @(negedge clk);
        cmp_cycle();
        check("rst_txd", {31'd0, txd}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1);
        rd(2'd1, 32'h1, 32'hFFFF_FFFF, "post_reset_status");
        rd(2'd3, 32'h0, 32'hFFFF_FFFF, "post_reset_txbuf");
        rd(2'd2, 32'h0, 32'hFFFF_FFFF, "post_reset_rxbuf");
        step(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
